instr_control: RTL and testbench
================================

# instr_control

Multi-cycle instruction decode and control stage of the simple processor. It sits directly upstream of the register file and ALU. It accepts one 32-bit instruction per handshake and latches it. It then drives the register-file read/write addresses and the ALU control fields, and pulses the register-file write enable exactly once per instruction.

## Interface
- Parameters: none; all widths are fixed by the processor ISA.
- `CLK` input 1 – single clock; all state updates on the rising edge.
- `RESET` input 1 – synchronous, active-high reset; sampled on the rising edge of `CLK`.
- `INSTRUCTION` input 32 – instruction word; `[31:24]` OPCODE, `[18:16]` RD, `[10:8]` RT, `[2:0]` RS, `[7:0]` IMMEDIATE.
- `INSTR_VALID` input 1 – `INSTRUCTION` is valid this cycle.
- `INSTR_READY` output 1 – the stage accepts an instruction this cycle.
- `INADDRESS` output 3 – register-file write address (RD).
- `OUT1ADDRESS` output 3 – register-file read port 1 address (RT).
- `OUT2ADDRESS` output 3 – register-file read port 2 address (RS).
- `WRITE` output 1 – register-file write enable; a one-cycle pulse.
- `IMMEDIATE` output 8 – immediate field taken from the latched instruction.
- `IMMSEL` output 1 – ALU operand 2 comes from `IMMEDIATE` instead of `OUT2`.
- `NEGSEL` output 1 – ALU operand 2 is the two's complement of `OUT2`.
- `ALUOP` output 3 – ALU function code.
- `INSTR_COUNT` output 16 – number of retired instructions.
- `ERROR` output 1 – illegal opcode flag; present only when `ILLEGAL_OP_TRAP_EN` is defined.

## Operation
- Opcode decode:
  - `0x00` loadi: `ALUOP=000`, `IMMSEL=1`.
  - `0x01` mov: `ALUOP=000`.
  - `0x02` add: `ALUOP=001`.
  - `0x03` sub: `ALUOP=001`, `NEGSEL=1`.
  - `0x04` and: `ALUOP=010`.
  - `0x05` or: `ALUOP=011`.
  - Any other opcode is illegal.
- FSM states: IDLE, DECODE, EXEC, WB (plus HALT when `ILLEGAL_OP_TRAP_EN` is defined).
- IDLE: `INSTR_READY=1`. If `INSTR_VALID`, latch `INSTRUCTION` into the instruction register (IR) and go to DECODE; otherwise stay in IDLE.
- DECODE: all address and ALU outputs are driven from the IR. The register-file read latency elapses here. Go to EXEC.
- EXEC: the ALU result settles. Go to WB.
- WB:
  - `WRITE=1` for this cycle only; the register file commits on the rising edge that ends WB.
  - `INSTR_COUNT` increments on that same edge and wraps from 0xFFFF to 0x0000.
  - `INSTR_READY=1` in WB as well. If `INSTR_VALID` is high, the next instruction is latched and the FSM goes straight to DECODE; otherwise it goes to IDLE.
- Back-to-back instructions therefore take 3 cycles each.
- Address and ALU outputs are registered from the IR. They change only on the edge that latches a new instruction, and are stable for the whole of DECODE, EXEC and WB.
- Capturing a new instruction on the edge that ends WB does not corrupt the write: the register file samples the old `INADDRESS` and `IN` on that edge.
- Illegal opcode without the trap: treated as a NOP. The instruction passes through all states with `WRITE` held 0 in WB, and `INSTR_COUNT` still increments.
- `INSTR_VALID` asserted while `INSTR_READY=0` is ignored. The instruction is not latched and the upstream stage must hold it.

## Timing
- `RESET` high at a rising edge takes priority over every other event, including `INSTR_VALID` and mid-instruction states. At that edge:
  - state → IDLE, IR → 0.
  - `INADDRESS`, `OUT1ADDRESS`, `OUT2ADDRESS` → 0.
  - `IMMEDIATE` → 0; `IMMSEL`, `NEGSEL` → 0; `ALUOP` → 000.
  - `WRITE` → 0; `INSTR_COUNT` → 0; `ERROR` → 0.
  - Any in-flight instruction is discarded without a write.
- `INSTR_READY` is forced to 0 while `RESET` is high. It is 1 in the first cycle after `RESET` falls.
- Handshake to write latency: an instruction accepted at edge N has `WRITE` high during the cycle between edges N+2 and N+3. The register-file write occurs at edge N+3.
- `WRITE` is never high in two consecutive cycles.

## Configuration
- Macro: `ILLEGAL_OP_TRAP_EN`.
- Defined:
  - An illegal opcode latched into the IR moves the FSM from DECODE to HALT and sets `ERROR=1`.
  - In HALT, `WRITE=0` and `INSTR_READY=0`, `INSTR_COUNT` holds, and the FSM stays there until `RESET`.
- Not defined: the `ERROR` port and HALT state are absent, and illegal opcodes behave as NOPs.

## Test plan
- Reset: assert `RESET` for 2 cycles with `INSTR_VALID=1` → all outputs 0, `INSTR_READY=0`; the cycle after release, `INSTR_READY=1`.
- loadi: instruction `0x00040023` → `INADDRESS=4`, `IMMEDIATE=0x23`, `IMMSEL=1`, `ALUOP=000`; `WRITE` high exactly 2 cycles after acceptance, for 1 cycle; `INSTR_COUNT=1`.
- Back-to-back: `INSTR_VALID` held high with sub `0x03020105` then add `0x02030201` → acceptances 3 cycles apart. The first instruction shows `NEGSEL=1`, `OUT1ADDRESS=1`, `OUT2ADDRESS=5`; the second shows `NEGSEL=0`, `INADDRESS=3`. Two `WRITE` pulses, never adjacent.
- Reset mid-op: assert `RESET` in EXEC of `0x05010203` → no `WRITE` pulse, `INSTR_COUNT` stays 0, state returns to IDLE.
- Counter wrap: force `INSTR_COUNT` to 0xFFFF, retire one instruction → 0x0000.
- Illegal opcode `0x7F000000`:
  - Without `ILLEGAL_OP_TRAP_EN`: no `WRITE`, count +1, `INSTR_READY` returns.
  - With `ILLEGAL_OP_TRAP_EN`: `ERROR=1`, `INSTR_READY` stuck at 0 until `RESET`.

Source files
------------

// File: rtl/instr_control.sv
// instr_control: multi-cycle decode/control stage driving register-file addresses and ALU controls.
// Optional illegal-opcode trap (HALT state, ERROR port) enabled by defining ILLEGAL_OP_TRAP_EN.
module instr_control (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  input  logic        INSTR_VALID,
  output logic        INSTR_READY,
  output logic [2:0]  INADDRESS,
  output logic [2:0]  OUT1ADDRESS,
  output logic [2:0]  OUT2ADDRESS,
  output logic        WRITE,
  output logic [7:0]  IMMEDIATE,
  output logic        IMMSEL,
  output logic        NEGSEL,
  output logic [2:0]  ALUOP,
  output logic [15:0] INSTR_COUNT
`ifdef ILLEGAL_OP_TRAP_EN
  ,
  output logic        ERROR
`endif
);

  localparam int unsigned CNT_W = 16;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_WB     = 3'd3;
`ifdef ILLEGAL_OP_TRAP_EN
  localparam logic [2:0] ST_HALT   = 3'd4;
`endif

  logic [2:0]       state_q, state_d;
  logic             accept_c;
  logic             ready_c;
  logic             legal_q;
  logic             dec_legal_c, dec_immsel_c, dec_negsel_c;
  logic [2:0]       dec_aluop_c;
  logic [CNT_W-1:0] count_q;
  logic             write_q;
  logic             unused_bits;

  assign unused_bits = ^{INSTRUCTION[23:19], INSTRUCTION[15:11]};

  // Opcode decode of the incoming word; the result is captured together with the IR fields.
  always_comb begin
    dec_legal_c  = 1'b1;
    dec_immsel_c = 1'b0;
    dec_negsel_c = 1'b0;
    dec_aluop_c  = 3'b000;
    case (INSTRUCTION[31:24])
      8'h00: dec_immsel_c = 1'b1;
      8'h01: dec_aluop_c  = 3'b000;
      8'h02: dec_aluop_c  = 3'b001;
      8'h03: begin
        dec_aluop_c  = 3'b001;
        dec_negsel_c = 1'b1;
      end
      8'h04: dec_aluop_c  = 3'b010;
      8'h05: dec_aluop_c  = 3'b011;
      default: dec_legal_c = 1'b0;
    endcase
  end

  // Next-state logic; WB doubles as an accept slot so back-to-back instructions take 3 cycles.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    ready_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_c = 1'b1;
        if (INSTR_VALID) begin
          accept_c = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
`ifdef ILLEGAL_OP_TRAP_EN
        state_d = legal_q ? ST_EXEC : ST_HALT;
`else
        state_d = ST_EXEC;
`endif
      end
      ST_EXEC: state_d = ST_WB;
      ST_WB: begin
        ready_c = 1'b1;
        if (INSTR_VALID) begin
          accept_c = 1'b1;
          state_d  = ST_DECODE;
        end else begin
          state_d = ST_IDLE;
        end
      end
`ifdef ILLEGAL_OP_TRAP_EN
      ST_HALT: state_d = ST_HALT;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // IR fields and decoded controls change only on the accepting edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      INADDRESS   <= 3'd0;
      OUT1ADDRESS <= 3'd0;
      OUT2ADDRESS <= 3'd0;
      IMMEDIATE   <= 8'd0;
      IMMSEL      <= 1'b0;
      NEGSEL      <= 1'b0;
      ALUOP       <= 3'b000;
      legal_q     <= 1'b0;
    end else if (accept_c) begin
      INADDRESS   <= INSTRUCTION[18:16];
      OUT1ADDRESS <= INSTRUCTION[10:8];
      OUT2ADDRESS <= INSTRUCTION[2:0];
      IMMEDIATE   <= INSTRUCTION[7:0];
      IMMSEL      <= dec_immsel_c;
      NEGSEL      <= dec_negsel_c;
      ALUOP       <= dec_aluop_c;
      legal_q     <= dec_legal_c;
    end
  end

  // Write pulse covers exactly the WB cycle of a legal instruction; retirement counted as WB ends.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      write_q <= 1'b0;
      count_q <= '0;
    end else begin
      write_q <= (state_d == ST_WB) && legal_q;
      if (state_q == ST_WB) count_q <= count_q + CNT_W'(1);
    end
  end

`ifdef ILLEGAL_OP_TRAP_EN
  always_ff @(posedge CLK) begin
    if (RESET)                                          ERROR <= 1'b0;
    else if (state_q == ST_DECODE && state_d == ST_HALT) ERROR <= 1'b1;
  end
`endif

  assign WRITE       = write_q;
  assign INSTR_COUNT = count_q;
  assign INSTR_READY = ready_c & ~RESET;

endmodule

// File: tb/tb_instr_control.sv
// Randomized self-checking bench for instr_control against a cycle-age reference model.
// Define ILLEGAL_OP_TRAP_EN for both bench and RTL to exercise the trap build.
module tb_instr_control;

  logic        CLK;
  logic        RESET;
  logic [31:0] INSTRUCTION;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [2:0]  INADDRESS, OUT1ADDRESS, OUT2ADDRESS, ALUOP;
  logic        WRITE, IMMSEL, NEGSEL;
  logic [7:0]  IMMEDIATE;
  logic [15:0] INSTR_COUNT;
`ifdef ILLEGAL_OP_TRAP_EN
  logic        ERROR;
`endif

  instr_control dut (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY), .INADDRESS(INADDRESS), .OUT1ADDRESS(OUT1ADDRESS),
    .OUT2ADDRESS(OUT2ADDRESS), .WRITE(WRITE), .IMMEDIATE(IMMEDIATE), .IMMSEL(IMMSEL),
    .NEGSEL(NEGSEL), .ALUOP(ALUOP), .INSTR_COUNT(INSTR_COUNT)
`ifdef ILLEGAL_OP_TRAP_EN
    , .ERROR(ERROR)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: an accepted instruction ages one step per edge; age 2 is its write-back cycle.
  bit          m_busy, m_legal, m_immsel, m_negsel, m_halt, m_err;
  int          m_age;
  logic [2:0]  m_rd, m_rt, m_rs, m_aluop;
  logic [7:0]  m_imm;
  logic [15:0] m_count;
  logic [2:0]  alu_tab [6] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3};

  function automatic bit trap_on();
`ifdef ILLEGAL_OP_TRAP_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge CLK) begin
    bit rdy;
    logic [7:0] op;
    rdy = !m_halt && (!m_busy || m_age == 2);
    if (RESET) begin
      {m_busy, m_legal, m_immsel, m_negsel, m_halt, m_err} = '0;
      m_age = 0; m_rd = 0; m_rt = 0; m_rs = 0; m_aluop = 0; m_imm = 0; m_count = 0;
    end else begin
      if (m_busy) begin
        if (m_age == 2) begin
          m_busy = 1'b0;
          m_count = m_count + 16'd1;
        end else begin
          m_age++;
          if (trap_on() && m_age == 1 && !m_legal) begin
            m_halt = 1'b1; m_err = 1'b1; m_busy = 1'b0;
          end
        end
      end
      if (rdy && INSTR_VALID) begin
        op = INSTRUCTION[31:24];
        m_busy  = 1'b1;
        m_age   = 0;
        m_legal = (op <= 8'd5);
        m_rd  = INSTRUCTION[18:16];
        m_rt  = INSTRUCTION[10:8];
        m_rs  = INSTRUCTION[2:0];
        m_imm = INSTRUCTION[7:0];
        m_aluop  = m_legal ? alu_tab[op[2:0]] : 3'd0;
        m_immsel = (op == 8'h00);
        m_negsel = (op == 8'h03);
      end
    end
    #1;
    if (chk_en) begin
      check("ready", 32'(INSTR_READY), 32'(!RESET && !m_halt && (!m_busy || m_age == 2)));
      check("write", 32'(WRITE), 32'(m_busy && m_age == 2 && m_legal));
      check("inaddr", 32'(INADDRESS), 32'(m_rd));
      check("out1", 32'(OUT1ADDRESS), 32'(m_rt));
      check("out2", 32'(OUT2ADDRESS), 32'(m_rs));
      check("imm", 32'(IMMEDIATE), 32'(m_imm));
      check("immsel", 32'(IMMSEL), 32'(m_immsel));
      check("negsel", 32'(NEGSEL), 32'(m_negsel));
      check("aluop", 32'(ALUOP), 32'(m_aluop));
      check("count", 32'(INSTR_COUNT), 32'(m_count));
`ifdef ILLEGAL_OP_TRAP_EN
      check("error", 32'(ERROR), 32'(m_err));
`endif
    end
  end

  task automatic drive(input bit v, input logic [31:0] ins, input bit r);
    @(negedge CLK);
    INSTR_VALID = v;
    INSTRUCTION = ins;
    RESET = r;
  endtask

  initial begin
    int wcnt;
    logic [31:0] ins;
    RESET = 1'b1; INSTR_VALID = 1'b0; INSTRUCTION = '0;

    // Reset held with a valid instruction pending
    drive(1'b1, 32'h00040023, 1'b1);
    #1 check("rst_ready0", 32'(INSTR_READY), 32'd0);
    drive(1'b1, 32'h00040023, 1'b1);
    chk_en = 1'b1;
    #1 check("rst_ready1", 32'(INSTR_READY), 32'd0);
    check("rst_outs", {INADDRESS, OUT1ADDRESS, OUT2ADDRESS, ALUOP, IMMEDIATE, WRITE, IMMSEL, NEGSEL}, 32'd0);
    check("rst_count", 32'(INSTR_COUNT), 32'd0);
    drive(1'b0, 32'h0, 1'b0);
    #1 check("rel_ready", 32'(INSTR_READY), 32'd1);

    // loadi
    drive(1'b1, 32'h00040023, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    check("ld_rd", 32'(INADDRESS), 32'd4);
    check("ld_imm", 32'(IMMEDIATE), 32'h23);
    check("ld_immsel", 32'(IMMSEL), 32'd1);
    check("ld_aluop", 32'(ALUOP), 32'd0);
    check("ld_w0", 32'(WRITE), 32'd0);
    drive(1'b0, 32'h0, 1'b0);
    check("ld_w1", 32'(WRITE), 32'd0);
    drive(1'b0, 32'h0, 1'b0);
    check("ld_w2", 32'(WRITE), 32'd1);
    drive(1'b0, 32'h0, 1'b0);
    check("ld_w3", 32'(WRITE), 32'd0);
    check("ld_count", 32'(INSTR_COUNT), 32'd1);

    // Back-to-back sub then add
    drive(1'b1, 32'h03020105, 1'b0);
    drive(1'b1, 32'h02030201, 1'b0);
    check("b2b_neg1", 32'(NEGSEL), 32'd1);
    check("b2b_out1", 32'(OUT1ADDRESS), 32'd1);
    check("b2b_out2", 32'(OUT2ADDRESS), 32'd5);
    wcnt = 0;
    for (int i = 0; i < 7; i++) begin
      if (WRITE) wcnt++;
      drive(i < 2, 32'h02030201, 1'b0);
      if (i == 2) begin
        check("b2b_neg2", 32'(NEGSEL), 32'd0);
        check("b2b_rd2", 32'(INADDRESS), 32'd3);
      end
    end
    check("b2b_writes", 32'(wcnt), 32'd2);
    check("b2b_count", 32'(INSTR_COUNT), 32'd3);

    // Reset during EXEC
    drive(1'b1, 32'h05010203, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b1);
    wcnt = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b0);
      if (WRITE) wcnt++;
    end
    check("mid_writes", 32'(wcnt), 32'd0);
    check("mid_count", 32'(INSTR_COUNT), 32'd0);
    check("mid_ready", 32'(INSTR_READY), 32'd1);

    // Counter wrap
    @(negedge CLK);
    force dut.count_q = 16'hFFFF;
    m_count = 16'hFFFF;
    @(negedge CLK);
    release dut.count_q;
    drive(1'b1, 32'h01010203, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 1'b0);
    check("wrap_count", 32'(INSTR_COUNT), 32'd0);

    // Illegal opcode
    drive(1'b1, 32'h7F000000, 1'b0);
    wcnt = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'h0, 1'b0);
      if (WRITE) wcnt++;
    end
    check("ill_writes", 32'(wcnt), 32'd0);
`ifdef ILLEGAL_OP_TRAP_EN
    check("ill_err", 32'(ERROR), 32'd1);
    check("ill_ready", 32'(INSTR_READY), 32'd0);
    check("ill_count", 32'(INSTR_COUNT), 32'd0);
    drive(1'b0, 32'h0, 1'b1);
    drive(1'b0, 32'h0, 1'b0);
`else
    check("ill_count", 32'(INSTR_COUNT), 32'd1);
    check("ill_ready", 32'(INSTR_READY), 32'd1);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      ins = $urandom;
      if ($urandom_range(0, 7) < 7) ins[31:24] = 8'($urandom_range(0, 5));
      drive(1'($urandom_range(0, 1)), ins, $urandom_range(0, 99) < (trap_on() ? 3 : 1));
    end
    drive(1'b0, 32'h0, 1'b0);
    @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
